// File: rtl/cpu_fsm_ctrl_pkg.sv
// Shared encodings for the lab CPU controller: states, register/write-back selects,
// opcode and ALU op fields, and the control-word bundle driven into the datapath.
package cpu_fsm_ctrl_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned NSEL_W  = 3;
  localparam int unsigned VSEL_W  = 2;
  localparam int unsigned OPC_W   = 3;
  localparam int unsigned OP_W    = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_WAIT   = 4'd0,
    ST_DECODE = 4'd1,
    ST_WR_IMM = 4'd2,
    ST_GET_A  = 4'd3,
    ST_GET_B  = 4'd4,
    ST_EXEC   = 4'd5,
    ST_EXEC_Z = 4'd6,
    ST_CMP    = 4'd7,
    ST_WR_C   = 4'd8
  } state_t;

  localparam logic [NSEL_W-1:0] NSEL_NONE = 3'b000;
  localparam logic [NSEL_W-1:0] NSEL_RN   = 3'b001;
  localparam logic [NSEL_W-1:0] NSEL_RD   = 3'b010;
  localparam logic [NSEL_W-1:0] NSEL_RM   = 3'b100;

  localparam logic [VSEL_W-1:0] VSEL_C     = 2'b00;
  localparam logic [VSEL_W-1:0] VSEL_IMM   = 2'b01;
  localparam logic [VSEL_W-1:0] VSEL_MDATA = 2'b10;
  localparam logic [VSEL_W-1:0] VSEL_PC    = 2'b11;

  localparam logic [OPC_W-1:0] OPC_MOV = 3'b110;
  localparam logic [OPC_W-1:0] OPC_ALU = 3'b101;

  localparam logic [OP_W-1:0] MOV_IMM = 2'b10;
  localparam logic [OP_W-1:0] MOV_REG = 2'b00;
  localparam logic [OP_W-1:0] ALU_ADD = 2'b00;
  localparam logic [OP_W-1:0] ALU_CMP = 2'b01;
  localparam logic [OP_W-1:0] ALU_AND = 2'b10;
  localparam logic [OP_W-1:0] ALU_MVN = 2'b11;

  typedef struct packed {
    logic              w;
    logic [NSEL_W-1:0] nsel;
    logic [VSEL_W-1:0] vsel;
    logic              write;
    logic              loada;
    logic              loadb;
    logic              asel;
    logic              bsel;
    logic              loadc;
    logic              loads;
  } ctrl_t;

  // Moore output table: control word asserted while sitting in a given state.
  function automatic ctrl_t state_ctrl(input state_t st);
    ctrl_t c;
    c = '0;
    case (st)
      ST_WAIT:   c.w = 1'b1;
      ST_WR_IMM: begin c.nsel = NSEL_RN; c.vsel = VSEL_IMM; c.write = 1'b1; end
      ST_GET_A:  begin c.nsel = NSEL_RN; c.loada = 1'b1; end
      ST_GET_B:  begin c.nsel = NSEL_RM; c.loadb = 1'b1; end
      ST_EXEC:   c.loadc = 1'b1;
      ST_EXEC_Z: begin c.asel = 1'b1; c.loadc = 1'b1; end
      ST_CMP:    c.loads = 1'b1;
      ST_WR_C:   begin c.nsel = NSEL_RD; c.vsel = VSEL_C; c.write = 1'b1; end
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cpu_fsm_ctrl.sv
// Moore sequencer for the lab CPU datapath: one instruction per start, back to WAIT.
// Control word is registered from the next state; datapath enables are gated by reset.
module cpu_fsm_ctrl
  import cpu_fsm_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              i_reset,
  input  logic              i_s,
  input  logic [OPC_W-1:0]  i_opcode,
  input  logic [OP_W-1:0]   i_op,
  output logic              o_w,
  output logic [NSEL_W-1:0] o_nsel,
  output logic [VSEL_W-1:0] o_vsel,
  output logic              o_write,
  output logic              o_loada,
  output logic              o_loadb,
  output logic              o_asel,
  output logic              o_bsel,
  output logic              o_loadc,
  output logic              o_loads
);

  state_t r_state;
  state_t w_next_state;
  ctrl_t  r_ctrl;
  ctrl_t  w_next_ctrl;

  // State and control-word registers; control word always matches r_state.
  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state <= ST_WAIT;
      r_ctrl  <= state_ctrl(ST_WAIT);
    end else begin
      r_state <= w_next_state;
      r_ctrl  <= w_next_ctrl;
    end
  end

  // Next-state logic; unused encodings fall through to WAIT.
  always_comb begin
    w_next_state = ST_WAIT;
    case (r_state)
      ST_WAIT:   w_next_state = i_s ? ST_DECODE : ST_WAIT;
      ST_DECODE: begin
        if (i_opcode == OPC_MOV && i_op == MOV_IMM)
          w_next_state = ST_WR_IMM;
        else if (i_opcode == OPC_MOV && i_op == MOV_REG)
          w_next_state = ST_GET_B;
        else if (i_opcode == OPC_ALU && i_op == ALU_MVN)
          w_next_state = ST_GET_B;
        else if (i_opcode == OPC_ALU)
          w_next_state = ST_GET_A;
        else
          w_next_state = ST_WAIT;
      end
      ST_WR_IMM: w_next_state = ST_WAIT;
      ST_GET_A:  w_next_state = ST_GET_B;
      ST_GET_B: begin
        // MOV reg and MVN pass B through the ALU with A forced to zero.
        if (i_opcode == OPC_MOV || i_op == ALU_MVN)
          w_next_state = ST_EXEC_Z;
        else if (i_op == ALU_CMP)
          w_next_state = ST_CMP;
        else
          w_next_state = ST_EXEC;
      end
      ST_EXEC:   w_next_state = ST_WR_C;
      ST_EXEC_Z: w_next_state = ST_WR_C;
      ST_CMP:    w_next_state = ST_WAIT;
      ST_WR_C:   w_next_state = ST_WAIT;
      default:   w_next_state = ST_WAIT;
    endcase
  end

  // Output decode; load/write enables are suppressed while reset is held.
  always_comb begin
    w_next_ctrl = state_ctrl(w_next_state);
    o_w     = r_ctrl.w;
    o_nsel  = r_ctrl.nsel;
    o_vsel  = r_ctrl.vsel;
    o_asel  = r_ctrl.asel;
    o_bsel  = r_ctrl.bsel;
    o_write = r_ctrl.write & ~i_reset;
    o_loada = r_ctrl.loada & ~i_reset;
    o_loadb = r_ctrl.loadb & ~i_reset;
    o_loadc = r_ctrl.loadc & ~i_reset;
    o_loads = r_ctrl.loads & ~i_reset;
  end

endmodule
